// File: rtl/mdu_sched.sv
// HI/LO owner and multi-cycle mult/div sequencer for the five-stage MIPS pipeline.
// Results are computed at the start edge and held until the configured latency expires.
module mdu_sched #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_uses_md,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_rdata
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pendHi_q, pendHi_d, pendLo_q, pendLo_d;

  logic        isMul, isDiv, signedOp;
  logic [63:0] mulA, mulB, prod;
  logic [31:0] absA, absB, divisor, quo, rem, quoRes, remRes;

  // Signed division runs on magnitudes so 0x80000000 / -1 never overflows.
  always_comb begin
    isMul    = (md_op == OP_MULT) || (md_op == OP_MULTU);
    isDiv    = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    signedOp = (md_op == OP_MULT) || (md_op == OP_DIV);
    mulA     = signedOp ? {{32{A[31]}}, A} : {32'b0, A};
    mulB     = signedOp ? {{32{B[31]}}, B} : {32'b0, B};
    prod     = mulA * mulB;
    absA     = (signedOp && A[31]) ? -A : A;
    absB     = (signedOp && B[31]) ? -B : B;
    divisor  = (absB == 32'd0) ? 32'd1 : absB;
    quo      = absA / divisor;
    rem      = absA % divisor;
    quoRes   = (signedOp && (A[31] ^ B[31])) ? -quo : quo;
    remRes   = (signedOp && A[31]) ? -rem : rem;
  end

  assign busy     = (state_q == RUN);
  assign start    = op_valid && (state_q == IDLE) && (isMul || isDiv);
  assign stall_md = (start | busy) & D_uses_md;
  assign HI       = hi_q;
  assign LO       = lo_q;

  always_comb begin
    md_rdata = 32'd0;
    if (md_op == OP_MFHI) md_rdata = hi_q;
    else if (md_op == OP_MFLO) md_rdata = lo_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    pendHi_d = pendHi_q;
    pendLo_d = pendLo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          if (isMul) begin
            cnt_d    = 4'(MULT_LAT);
            pendHi_d = prod[63:32];
            pendLo_d = prod[31:0];
          end else begin
            cnt_d = 4'(DIV_LAT);
            // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
            if (B == 32'd0) begin
              pendHi_d = hi_q;
              pendLo_d = lo_q;
            end else begin
              pendHi_d = remRes;
              pendLo_d = quoRes;
            end
          end
        end else if (op_valid && (md_op == OP_MTHI)) begin
          hi_d = A;
        end else if (op_valid && (md_op == OP_MTLO)) begin
          lo_d = A;
        end
      end
      RUN: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          hi_d    = pendHi_q;
          lo_d    = pendLo_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      pendHi_q <= 32'd0;
      pendLo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pendHi_q <= pendHi_d;
      pendLo_q <= pendLo_d;
    end
  end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multiply/divide scheduler for the five-stage MIPS pipeline.
- Owns the HI/LO register pair and sequences multi-cycle mult/multu/div/divu operations issued from the E stage.
- Serves mfhi/mflo/mthi/mtlo accesses.
- Raises a stall request to the hazard unit while a D-stage MD instruction would collide with an in-flight operation.

Parameters:
- MULT_LAT, 5, cycles from start until HI/LO are committed for mult/multu; legal range 1..15.
- DIV_LAT, 10, cycles from start until HI/LO are committed for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- op_valid  input  1  E-stage instruction is valid (not bubble/flushed).
- md_op  input  4  E-stage MD op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 treated as none.
- A  input  32  E-stage forwarded rs value.
- B  input  32  E-stage forwarded rt value.
- D_uses_md  input  1  D-stage instruction is any of the eight MD ops.
- start  output  1  combinational; E-stage mult/multu/div/divu accepted this cycle.
- busy  output  1  registered; an operation is in flight.
- stall_md  output  1  combinational; (start | busy) & D_uses_md.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.
- md_rdata  output  32  combinational: HI when md_op=5, LO when md_op=6, else 0.

Behaviour:
- Reset values: HI=0, LO=0, busy=0, counter=0, pending regs=0, state IDLE. start, stall_md and md_rdata follow their equations.
- Reset asserted mid-operation aborts it. No commit occurs and HI/LO return to 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE -> RUN:
  - Condition: op_valid & md_op in {1,2,3,4}. start=1 in that cycle.
  - At the edge: compute the result, latch it into pending_hi/pending_lo, and load counter with MULT_LAT (ops 1,2) or DIV_LAT (ops 3,4).
- RUN behaviour:
  - Counter decrements each edge.
  - On the edge where counter==1: HI<=pending_hi, LO<=pending_lo, busy->0, state->IDLE.
  - Total: HI/LO become visible exactly LAT edges after the start edge.
  - busy is high for exactly LAT cycles.
- Arithmetic:
  - mult: signed 32x32->64; HI=upper 32 bits, LO=lower 32 bits.
  - multu: the same, unsigned.
  - div: LO=signed quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Division boundary cases:
  - Divide by zero (B=0): operation still occupies DIV_LAT cycles. At commit, HI and LO keep their pre-start values.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: in IDLE with op_valid, HI<=A (op 7) or LO<=A (op 8) at the next edge. No busy.
- mfhi/mflo: md_rdata is combinational from the current HI/LO. In the cycle of a commit edge, the old value is read before the edge.
- Any MD op (1..8) presented with op_valid while busy=1 is ignored: no state change, start=0. The hazard unit guarantees this does not occur; the block remains safe if it does.
- A start in the same cycle that the previous operation commits cannot happen: busy=1 during that cycle, so the new op is ignored.
- op_valid=0 makes md_op a don't-care: no state change, md_rdata=0 if md_op is not 5/6.
- stall_md is purely combinational. The block has no knowledge of which D-stage op is present beyond D_uses_md.

Test Plan:
- Reset, then mult A=0xFFFFFFFE (-2), B=3 -> start=1 for one cycle; busy=1 for 5 cycles; after the 5th edge HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2 -> after 5 edges HI=0x00000001, LO=0xFFFFFFFE; stall_md=1 every busy cycle with D_uses_md=1, and 0 on the first cycle after commit.
- div A=0xFFFFFFF9 (-7), B=2 -> after 10 edges LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 with HI=0x11, LO=0x22 preset -> after 10 edges HI=0x11, LO=0x22.
- mthi A=0xDEADBEEF, then mflo/mfhi next cycle -> HI=0xDEADBEEF immediately after one edge, md_rdata=0xDEADBEEF for md_op=5; mtlo presented while busy -> LO unchanged.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; second mult issued on cycle 3 of busy -> ignored, start=0, result of first op unaffected.
- Assert reset on cycle 2 of a mult run -> busy=0, HI=LO=0 immediately (asynchronous), no later commit after reset deasserts.
